inta_cycle_initiator: RTL and testbench
=======================================

// Module: inta_cycle_initiator
//
// PURPOSE
// - CPU-side end of the PIC interrupt-acknowledge interface: sees INT from the PIC, runs the two-pulse INTA_n sequence, and latches the 8-bit vector the PIC data bus buffer drives on D.
// - Sits between the PIC pins (INT, INTA_n, D) and the CPU core; hands the vector to the core on a valid/ack handshake.
//
// PARAMETERS
// - INTA_LOW  default 2  cycles each INTA_n pulse is held low (>=1)
// - INTA_GAP  default 2  cycles INTA_n is high between the two pulses (>=1)
// - CNT_W     default 4  width of the pulse/gap counter; must hold max(INTA_LOW, INTA_GAP)
//
// PORTS
// - clk          in   1  system clock, all state changes on rising edge
// - rst          in   1  synchronous, active-high reset
// - int_req      in   1  INT from PIC, level, active high
// - int_en       in   1  CPU interrupt-enable flag (IF)
// - d_in         in   8  PIC data bus D, sampled only at the vector latch edge
// - vector_ack   in   1  core has consumed vector
// - inta_n       out  1  interrupt acknowledge to PIC, active low, registered
// - lock_n       out  1  bus lock, low from first INTA_n fall through second INTA_n rise
// - vector       out  8  latched interrupt vector
// - vector_valid out  1  vector holds a new, unconsumed value
// - busy         out  1  high in every state except IDLE
//
// BEHAVIOUR
// - Reset (sync, active high): state=IDLE, inta_n=1, lock_n=1, vector=8'h00, vector_valid=0, busy=0, counter=0.
// - Reset mid-sequence: the next edge forces all of the above; a pulse in flight ends immediately, and no partial vector is kept.
// - All outputs are registered; no combinational path from an input to inta_n or lock_n.
// - States and transitions:
//   - IDLE: if int_req & int_en at the edge -> INTA1; inta_n=0, lock_n=0 from that edge.
//   - INTA1: inta_n low for exactly INTA_LOW cycles -> GAP; inta_n=1, lock_n stays 0.
//   - GAP: INTA_GAP cycles -> INTA2; inta_n=0.
//   - INTA2: INTA_LOW cycles; on the edge ending the last low cycle: vector<=d_in, vector_valid<=1, inta_n<=1, lock_n<=1 -> WAIT_ACK.
//   - WAIT_ACK: hold vector and vector_valid until vector_ack=1 -> IDLE, vector_valid<=0. vector itself keeps its value.
// - Latency: if inta_n falls at edge E, vector_valid rises at edge E + 2*INTA_LOW + INTA_GAP. With the defaults this is E+6.
// - Once started, a sequence always completes, even if int_req or int_en drops mid-sequence; the PIC supplies the spurious vector.
// - int_req high while in WAIT_ACK is not accepted until IDLE is reached. IDLE samples again on the next edge, so back-to-back sequences are separated by >=1 idle cycle.
// - vector_ack outside WAIT_ACK: ignored.
// - vector_ack in the same cycle vector_valid rises: not consumed; the ack must be seen while in WAIT_ACK.
// - d_in is ignored in all cycles other than the latch edge, and bus X/Z at other times has no effect.
// - Counter counts 0..N-1 and reloads to 0 on every state change; it never wraps within a state.
//
// STRUCTURE
// - Shared package pic_pkg:
//   - state enum/localparams: IDLE, INTA1, GAP, INTA2, WAIT_ACK (3 bits)
//   - VEC_W=8
//   - default INTA_LOW/INTA_GAP constants
// - Sub-module inta_pulse_timer:
//   - loadable down/up counter, inputs start + terminal count
//   - output done in the last cycle of the interval
//   - reused for both the pulse and gap intervals.
// - Top level holds the FSM, the output registers and the vector latch.
//
// TESTING
// - Reset, then int_req=1, int_en=1: inta_n=0 for 2 cycles, 1 for 2, 0 for 2. lock_n is low for all 6 cycles. Drive d_in=8'h48 in the last low cycle -> vector=8'h48, vector_valid=1 at E+6.
// - int_en=0, int_req=1 for 20 cycles: inta_n, lock_n stay 1 and busy=0. Raise int_en -> sequence starts at the next edge.
// - int_req drops in GAP: the sequence still completes; d_in=8'h4F (IR7 spurious) is latched and vector_valid=1.
// - Assert rst during INTA2: the next edge gives inta_n=1, lock_n=1, vector=8'h00, vector_valid=0. The following int_req starts a fresh INTA1.
// - Hold vector_ack=0 for 10 cycles with int_req=1: vector is stable and no INTA_n pulses occur. Pulse vector_ack -> IDLE, vector_valid=0, and a new sequence starts one cycle later.
// - Override INTA_LOW=1, INTA_GAP=3: measure the pulse widths at 1/3/1 and check vector_valid at E+5. Drive d_in=8'hAA and check it is latched.

Source files
------------

// File: rtl/inta_cycle_initiator_pkg.sv
// Shared types and constants for the CPU-side interrupt-acknowledge initiator.
package inta_cycle_initiator_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INTA1    = 3'd1,
    GAP      = 3'd2,
    INTA2    = 3'd3,
    WAIT_ACK = 3'd4
  } state_t;

  localparam int VEC_W         = 8;
  localparam int DEF_INTA_LOW  = 2;
  localparam int DEF_INTA_GAP  = 2;
  localparam int DEF_CNT_W     = 4;

endpackage

// File: rtl/inta_cycle_initiator_if.sv
// PIC-facing pins plus the vector handshake toward the CPU core.
interface inta_cycle_initiator_if;
  import inta_cycle_initiator_pkg::*;

  logic             int_req;
  logic             int_en;
  logic [VEC_W-1:0] d_in;
  logic             vector_ack;
  logic             inta_n;
  logic             lock_n;
  logic [VEC_W-1:0] vector;
  logic             vector_valid;
  logic             busy;

  modport master (
    input  int_req, int_en, d_in, vector_ack,
    output inta_n, lock_n, vector, vector_valid, busy
  );

  modport slave (
    output int_req, int_en, d_in, vector_ack,
    input  inta_n, lock_n, vector, vector_valid, busy
  );

endinterface

// File: rtl/inta_cycle_initiator_pulse_timer.sv
// Interval timer shared by the INTA_n low pulses and the gap between them.
module inta_cycle_initiator_pulse_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] count;

  assign done = (count == term);

  // Holds at the terminal count instead of wrapping when a state lingers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (!done) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/inta_cycle_initiator.sv
// Runs the two-pulse INTA_n sequence when INT is taken and latches the vector off D.
module inta_cycle_initiator
  import inta_cycle_initiator_pkg::*;
#(
  parameter int INTA_LOW = DEF_INTA_LOW,
  parameter int INTA_GAP = DEF_INTA_GAP,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  inta_cycle_initiator_if.master  bus
);

  localparam logic [CNT_W-1:0] LOW_TC = CNT_W'(INTA_LOW - 1);
  localparam logic [CNT_W-1:0] GAP_TC = CNT_W'(INTA_GAP - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] term;
  logic             done;
  logic             start;

  inta_cycle_initiator_pulse_timer #(
    .CNT_W (CNT_W)
  ) timer (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .term  (term),
    .done  (done)
  );

  assign start = (state_next != state);

  always_comb begin
    state_next = state;
    term       = '0;
    case (state)
      IDLE: begin
        if (bus.int_req && bus.int_en) state_next = INTA1;
      end
      INTA1: begin
        term = LOW_TC;
        if (done) state_next = GAP;
      end
      GAP: begin
        term = GAP_TC;
        if (done) state_next = INTA2;
      end
      INTA2: begin
        term = LOW_TC;
        if (done) state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.vector_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pin outputs are decoded from the upcoming state so they change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.inta_n       <= 1'b1;
      bus.lock_n       <= 1'b1;
      bus.busy         <= 1'b0;
      bus.vector       <= '0;
      bus.vector_valid <= 1'b0;
    end else begin
      bus.inta_n <= !(state_next == INTA1 || state_next == INTA2);
      bus.lock_n <= !(state_next == INTA1 || state_next == GAP || state_next == INTA2);
      bus.busy   <= (state_next != IDLE);
      if (state == INTA2 && done) begin
        bus.vector       <= bus.d_in;
        bus.vector_valid <= 1'b1;
      end else if (state == WAIT_ACK && bus.vector_ack) begin
        bus.vector_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inta_cycle_initiator.sv
// Bench for inta_cycle_initiator: default timing (dut 0) and INTA_LOW=1/INTA_GAP=3 (dut 1).
module tb_inta_cycle_initiator;

  localparam int LOW0 = 2;
  localparam int GAP0 = 2;
  localparam int LOW1 = 1;
  localparam int GAP1 = 3;

  logic clk;
  logic rst;
  logic chk_en;

  int tests;
  int fails;
  int cyc;

  logic       req_s [2];
  logic       en_s  [2];
  logic       ack_s [2];
  logic [7:0] d_s   [2];

  logic       inta_o  [2];
  logic       lock_o  [2];
  logic       busy_o  [2];
  logic       valid_o [2];
  logic [7:0] vec_o   [2];

  int         m_start [2];
  logic       m_wait  [2];
  logic       m_valid [2];
  logic [7:0] m_vec   [2];

  inta_cycle_initiator_if ifc0 ();
  inta_cycle_initiator_if ifc1 ();

  assign ifc0.int_req    = req_s[0];
  assign ifc0.int_en     = en_s[0];
  assign ifc0.vector_ack = ack_s[0];
  assign ifc0.d_in       = d_s[0];
  assign ifc1.int_req    = req_s[1];
  assign ifc1.int_en     = en_s[1];
  assign ifc1.vector_ack = ack_s[1];
  assign ifc1.d_in       = d_s[1];

  assign inta_o[0]  = ifc0.inta_n;
  assign lock_o[0]  = ifc0.lock_n;
  assign busy_o[0]  = ifc0.busy;
  assign valid_o[0] = ifc0.vector_valid;
  assign vec_o[0]   = ifc0.vector;
  assign inta_o[1]  = ifc1.inta_n;
  assign lock_o[1]  = ifc1.lock_n;
  assign busy_o[1]  = ifc1.busy;
  assign valid_o[1] = ifc1.vector_valid;
  assign vec_o[1]   = ifc1.vector;

  inta_cycle_initiator dut0 (
    .clk (clk),
    .rst (rst),
    .bus (ifc0)
  );

  inta_cycle_initiator #(
    .INTA_LOW (LOW1),
    .INTA_GAP (GAP1),
    .CNT_W    (4)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (ifc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic req, input logic en,
                               input logic ack, input logic [7:0] d);
    req_s[idx] = req;
    en_s[idx]  = en;
    ack_s[idx] = ack;
    d_s[idx]   = d;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: a sequence is just its start edge; pulse shape follows from the offset since then.
  initial begin
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      m_start[d] = -1;
      m_wait[d]  = 1'b0;
      m_valid[d] = 1'b0;
      m_vec[d]   = 8'h00;
    end
  end

  always @(posedge clk) begin
    int n;
    int lw;
    int gp;
    n = cyc + 1;
    cyc <= n;
    for (int d = 0; d < 2; d++) begin
      lw = (d == 0) ? LOW0 : LOW1;
      gp = (d == 0) ? GAP0 : GAP1;
      if (rst) begin
        m_start[d] <= -1;
        m_wait[d]  <= 1'b0;
        m_valid[d] <= 1'b0;
        m_vec[d]   <= 8'h00;
      end else if (m_wait[d]) begin
        if (ack_s[d]) begin
          m_wait[d]  <= 1'b0;
          m_valid[d] <= 1'b0;
        end
      end else if (m_start[d] < 0) begin
        if (req_s[d] && en_s[d]) m_start[d] <= n;
      end else if (n - m_start[d] == 2 * lw + gp) begin
        m_vec[d]   <= d_s[d];
        m_valid[d] <= 1'b1;
        m_wait[d]  <= 1'b1;
        m_start[d] <= -1;
      end
    end
  end

  always @(negedge clk) begin
    int   off;
    int   lw;
    int   gp;
    logic active;
    logic e_inta;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        lw     = (d == 0) ? LOW0 : LOW1;
        gp     = (d == 0) ? GAP0 : GAP1;
        active = (m_start[d] >= 0);
        off    = cyc - m_start[d];
        e_inta = !(active && (off < lw || off >= lw + gp));
        checkOutput($sformatf("dut%0d inta_n", d), 8'(inta_o[d]), 8'(e_inta));
        checkOutput($sformatf("dut%0d lock_n", d), 8'(lock_o[d]), 8'(!active));
        checkOutput($sformatf("dut%0d busy", d), 8'(busy_o[d]), 8'(active || m_wait[d]));
        checkOutput($sformatf("dut%0d vector_valid", d), 8'(valid_o[d]), 8'(m_valid[d]));
        checkOutput($sformatf("dut%0d vector", d), vec_o[d], m_vec[d]);
      end
    end
  end

  initial begin
    logic p1 [7];
    logic p2 [6];
    p1 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    p2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tests  = 0;
    fails  = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(2);
    chk_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset inta_n", 8'(inta_o[d]), 8'h01);
      checkOutput("reset lock_n", 8'(lock_o[d]), 8'h01);
      checkOutput("reset busy", 8'(busy_o[d]), 8'h00);
      checkOutput("reset vector_valid", 8'(valid_o[d]), 8'h00);
      checkOutput("reset vector", vec_o[d], 8'h00);
    end

    // Basic sequence, D floats except in the last low cycle.
    rst = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'hxx);
    for (int i = 0; i < 7; i++) begin
      tick(1);
      checkOutput($sformatf("seq1 inta_n[%0d]", i), 8'(inta_o[0]), 8'(p1[i]));
      checkOutput($sformatf("seq1 lock_n[%0d]", i), 8'(lock_o[0]), (i < 6) ? 8'h00 : 8'h01);
      if (i == 5) applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'h48);
      if (i == 6) begin
        checkOutput("seq1 vector_valid", 8'(valid_o[0]), 8'h01);
        checkOutput("seq1 vector", vec_o[0], 8'h48);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'hxx);
      end
    end

    tick(10);
    checkOutput("hold vector", vec_o[0], 8'h48);
    checkOutput("hold inta_n", 8'(inta_o[0]), 8'h01);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 8'h5A);
    tick(1);
    checkOutput("ack vector_valid", 8'(valid_o[0]), 8'h00);
    checkOutput("ack busy", 8'(busy_o[0]), 8'h00);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'h5A);
    tick(1);
    checkOutput("restart inta_n", 8'(inta_o[0]), 8'h00);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'h5A);
    tick(6);
    checkOutput("restart vector", vec_o[0], 8'h5A);
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 8'h5A);
    tick(1);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'h00);

    // Interrupts masked, then enabled.
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick(20);
    checkOutput("masked inta_n", 8'(inta_o[0]), 8'h01);
    checkOutput("masked lock_n", 8'(lock_o[0]), 8'h01);
    checkOutput("masked busy", 8'(busy_o[0]), 8'h00);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'hxx);
    tick(1);
    checkOutput("enable inta_n", 8'(inta_o[0]), 8'h00);
    checkOutput("enable busy", 8'(busy_o[0]), 8'h01);

    // INT drops during the gap; spurious vector still collected.
    tick(2);
    checkOutput("gap inta_n", 8'(inta_o[0]), 8'h01);
    checkOutput("gap lock_n", 8'(lock_o[0]), 8'h00);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'hxx);
    tick(3);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'h4F);
    tick(1);
    checkOutput("spurious vector_valid", 8'(valid_o[0]), 8'h01);
    checkOutput("spurious vector", vec_o[0], 8'h4F);
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 8'hxx);
    tick(1);
    checkOutput("spurious ack", 8'(valid_o[0]), 8'h00);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'h00);

    // Reset while the second pulse is low.
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'h00);
    tick(1);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick(4);
    checkOutput("inta2 inta_n", 8'(inta_o[0]), 8'h00);
    rst = 1'b1;
    tick(1);
    checkOutput("midrst inta_n", 8'(inta_o[0]), 8'h01);
    checkOutput("midrst lock_n", 8'(lock_o[0]), 8'h01);
    checkOutput("midrst vector", vec_o[0], 8'h00);
    checkOutput("midrst vector_valid", 8'(valid_o[0]), 8'h00);
    checkOutput("midrst busy", 8'(busy_o[0]), 8'h00);
    rst = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'h33);
    tick(1);
    checkOutput("fresh inta_n", 8'(inta_o[0]), 8'h00);
    checkOutput("fresh lock_n", 8'(lock_o[0]), 8'h00);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'h33);
    tick(6);
    checkOutput("fresh vector", vec_o[0], 8'h33);
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 8'h33);
    tick(1);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'h00);

    // Short-pulse instance: 1/3/1 timing; ack during the latch cycle is ignored.
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 8'hxx);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checkOutput($sformatf("short inta_n[%0d]", i), 8'(inta_o[1]), 8'(p2[i]));
      checkOutput($sformatf("short lock_n[%0d]", i), 8'(lock_o[1]), (i < 5) ? 8'h00 : 8'h01);
      if (i == 4) applyStimulus(1, 1'b0, 1'b1, 1'b1, 8'hAA);
      if (i == 5) begin
        checkOutput("short vector_valid", 8'(valid_o[1]), 8'h01);
        checkOutput("short vector", vec_o[1], 8'hAA);
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 8'hxx);
      end
    end
    tick(1);
    checkOutput("early ack ignored", 8'(valid_o[1]), 8'h01);
    applyStimulus(1, 1'b0, 1'b1, 1'b1, 8'hxx);
    tick(1);
    checkOutput("short ack", 8'(valid_o[1]), 8'h00);
    checkOutput("short vector kept", vec_o[1], 8'hAA);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
